// File: rtl/cpu_sequencer.sv
// Control sequencer: one-hot cycle state, IR, imem handshake,
// call-stack depth guard, halt/step/fault control.
//
// Ports:
//   clk, reset        - rising-edge clock, sync active-high reset
//   run               - level, leaves IDLE
//   imem_ack          - imem returns imem_data this cycle
//   imem_data         - instruction opcode
//   resume            - pulse, leaves HALT
//   step_mode, step   - pause after each instr / advance one
//   state             - one-hot {exec2, exec1, fetch}
//   ir                - instruction register
//   imem_req          - fetch request
//   halted            - core in HALT
//   fault, fault_code - sticky fault (01 ovf, 10 unf, 11 timeout)
//   stack_depth       - call-stack occupancy
//   instr_count       - retired instructions, wraps at 16 bits
module cpu_sequencer #(
  parameter int           STACK_DEPTH = 4,
  parameter int           DW          = 3,
  parameter logic [4:0]   CALL_OP     = 5'b00100,
  parameter logic [4:0]   RET_OP      = 5'b00101,
  parameter logic [4:0]   HALT_OP     = 5'b11111,
  parameter int           ACK_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          imem_ack,
  input  logic [4:0]    imem_data,
  input  logic          resume,
  input  logic          step_mode,
  input  logic          step,
  output logic [2:0]    state,
  output logic [4:0]    ir,
  output logic          imem_req,
  output logic          halted,
  output logic          fault,
  output logic [1:0]    fault_code,
  output logic [DW-1:0] stack_depth,
  output logic [15:0]   instr_count
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [DW-1:0] D_FULL = DW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FREQ, S_FETCH, S_EXEC1,
    S_EXEC2, S_PAUSE, S_HALT, S_FAULT
  } fsm_t;

  fsm_t          fsm;
  fsm_t          nxt;
  logic [TW-1:0] tcnt;
  logic          ovf;
  logic          unf;

  assign ovf = (ir == CALL_OP) && (stack_depth == D_FULL);
  assign unf = (ir == RET_OP) && (stack_depth == '0);

  always_comb begin
    nxt = fsm;
    unique case (fsm)
      S_IDLE:  if (run) nxt = S_FREQ;
      S_FREQ: begin
        // an ack on the last allowed cycle beats the timeout
        if (imem_ack)            nxt = S_FETCH;
        else if (tcnt == T_LAST) nxt = S_FAULT;
      end
      S_FETCH: nxt = (ovf || unf) ? S_FAULT : S_EXEC1;
      S_EXEC1: nxt = (ir == HALT_OP) ? S_HALT : S_EXEC2;
      S_EXEC2: nxt = step_mode ? S_PAUSE : S_FREQ;
      S_PAUSE: if (step || !step_mode) nxt = S_FREQ;
      S_HALT:  if (resume) nxt = S_FREQ;
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm         <= S_IDLE;
      state       <= '0;
      ir          <= '0;
      imem_req    <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 2'b00;
      stack_depth <= '0;
      instr_count <= '0;
      tcnt        <= '0;
    end else begin
      fsm      <= nxt;
      // outputs track the registered FSM state
      state    <= {nxt == S_EXEC2, nxt == S_EXEC1, nxt == S_FETCH};
      imem_req <= (nxt == S_FREQ);
      halted   <= (nxt == S_HALT);
      unique case (fsm)
        S_FREQ: begin
          if (imem_ack) begin
            ir   <= imem_data;
            tcnt <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (nxt == S_FAULT) begin
              fault      <= 1'b1;
              fault_code <= 2'b11;
            end
          end
        end
        S_FETCH: begin
          if (ovf) begin
            fault      <= 1'b1;
            fault_code <= 2'b01;
          end else if (unf) begin
            fault      <= 1'b1;
            fault_code <= 2'b10;
          end
        end
        S_EXEC1: begin
          if (ir == HALT_OP)
            instr_count <= instr_count + 16'd1;
          else if (ir == CALL_OP)
            stack_depth <= stack_depth + 1'b1;
          else if (ir == RET_OP)
            stack_depth <= stack_depth - 1'b1;
        end
        S_EXEC2: instr_count <= instr_count + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer.
// Scoreboard of per-instruction results plus direct checks.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        imem_ack = 1'b0;
  logic [4:0]  imem_data = '0;
  logic        resume = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic [2:0]  state;
  logic [4:0]  ir;
  logic        imem_req;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_code;
  logic [2:0]  stack_depth;
  logic [15:0] instr_count;

  localparam logic [4:0] NOP  = 5'b00011;
  localparam logic [4:0] CALL = 5'b00100;
  localparam logic [4:0] RET  = 5'b00101;
  localparam logic [4:0] HLT  = 5'b11111;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  d;
    logic [15:0] c;
  } sb_t;

  sb_t q[$];
  int total = 0;
  int bad = 0;
  logic [2:0]  exp_d;
  logic [15:0] exp_c;

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .resume(resume), .step_mode(step_mode), .step(step),
    .state(state), .ir(ir), .imem_req(imem_req),
    .halted(halted), .fault(fault), .fault_code(fault_code),
    .stack_depth(stack_depth), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    exp_d = '0;
    exp_c = '0;
    q.delete();
  endtask

  task automatic start();
    run = 1'b1;
    cyc();
    run = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !imem_req; i++) cyc();
    check("req_wait", imem_req, 1);
  endtask

  task automatic sb_pop();
    sb_t e;
    if (q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = q.pop_front();
      check("sb_ir", ir, e.op);
      check("sb_depth", stack_depth, e.d);
      check("sb_count", instr_count, e.c);
    end
  endtask

  task automatic fetch(input logic [4:0] op);
    wait_req();
    imem_ack = 1'b1;
    imem_data = op;
    cyc();
    imem_ack = 1'b0;
    check("fetch_state", state, 3'b001);
    check("fetch_req", imem_req, 0);
  endtask

  task automatic do_instr(input logic [4:0] op);
    sb_t e;
    fetch(op);
    if (op == CALL) exp_d = exp_d + 1'b1;
    if (op == RET)  exp_d = exp_d - 1'b1;
    exp_c = exp_c + 16'd1;
    e.op = op;
    e.d = exp_d;
    e.c = exp_c;
    q.push_back(e);
    cyc();
    check("exec1_state", state, 3'b010);
    cyc();
    if (op == HLT) begin
      check("halt_state", state, 3'b000);
      check("halted", halted, 1);
    end else begin
      check("exec2_state", state, 3'b100);
      cyc();
      check("post_state", state, 3'b000);
    end
    sb_pop();
  endtask

  task automatic fault_instr(input logic [4:0] op,
                             input logic [1:0] code);
    fetch(op);
    cyc();
    check("flt_state", state, 3'b000);
    check("flt_flag", fault, 1);
    check("flt_code", fault_code, code);
    cyc();
    check("flt_hold", fault, 1);
    check("flt_no_exec", state, 3'b000);
  endtask

  initial begin
    exp_d = '0;
    exp_c = '0;
    do_reset();
    check("rst_state", state, 0);
    check("rst_ir", ir, 0);
    check("rst_req", imem_req, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_depth", stack_depth, 0);
    check("rst_count", instr_count, 0);

    // basic flow
    start();
    check("freq_req", imem_req, 1);
    check("freq_state", state, 0);
    for (int i = 0; i < 3; i++) do_instr(NOP);
    check("basic_count", instr_count, 3);

    // stack overflow
    for (int i = 0; i < 4; i++) do_instr(CALL);
    check("depth_full", stack_depth, 4);
    fault_instr(CALL, 2'b01);
    check("ovf_depth", stack_depth, 4);

    // stack underflow
    do_reset();
    start();
    fault_instr(RET, 2'b10);
    check("unf_depth", stack_depth, 0);

    // fetch timeout
    do_reset();
    start();
    for (int i = 0; i < 14; i++) cyc();
    check("to_pre", fault, 0);
    check("to_pre_req", imem_req, 1);
    cyc();
    check("to_fault", fault, 1);
    check("to_code", fault_code, 2'b11);

    // ack on the last allowed cycle
    do_reset();
    start();
    for (int i = 0; i < 14; i++) cyc();
    imem_ack = 1'b1;
    imem_data = NOP;
    cyc();
    imem_ack = 1'b0;
    check("to_ack_state", state, 3'b001);
    check("to_ack_fault", fault, 0);

    // halt / resume
    do_reset();
    start();
    do_instr(NOP);
    do_instr(HLT);
    step = 1'b1;
    run = 1'b1;
    cyc();
    step = 1'b0;
    run = 1'b0;
    check("halt_hold", halted, 1);
    check("halt_noreq", imem_req, 0);
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    check("resume_req", imem_req, 1);
    check("resume_halted", halted, 0);
    do_instr(NOP);

    // single-step
    step_mode = 1'b1;
    do_instr(CALL);
    for (int i = 0; i < 3; i++) cyc();
    check("pause_noreq", imem_req, 0);
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    check("pause_resume_ign", imem_req, 0);
    step = 1'b1;
    resume = 1'b1;
    cyc();
    step = 1'b0;
    resume = 1'b0;
    check("step_req", imem_req, 1);
    do_instr(RET);
    cyc();
    check("pause2_noreq", imem_req, 0);
    step_mode = 1'b0;
    cyc();
    check("free_req", imem_req, 1);
    do_instr(NOP);
    check("free_req2", imem_req, 1);

    // reset during EXEC1 of a call
    fetch(CALL);
    cyc();
    check("mid_exec1", state, 3'b010);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid_state", state, 0);
    check("mid_ir", ir, 0);
    check("mid_req", imem_req, 0);
    check("mid_depth", stack_depth, 0);
    check("mid_count", instr_count, 0);
    check("mid_fault", fault, 0);
    cyc();
    check("mid_idle", imem_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Control sequencer for the non-pipelined Harvard CPU core. It generates the one-hot cycle-state vector (fetch/exec1/exec2) consumed by the instruction decoder. It also owns the instruction register and the instruction-memory request handshake. It tracks call-stack depth, so stack overflow and underflow are caught before the decoder issues push/pop, and it provides halt, single-step and fault control.

Parameters:
STACK_DEPTH, 4, number of call-stack entries; valid depth 0..STACK_DEPTH
DW, 3, width of stack_depth output; must hold STACK_DEPTH
CALL_OP, 5'b00100, opcode that pushes (subroutine call)
RET_OP, 5'b00101, opcode that pops (return)
HALT_OP, 5'b11111, opcode that halts the core
ACK_TIMEOUT, 15, max cycles waiting for imem_ack before fault

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
run  in  1  level; start execution from IDLE
imem_ack  in  1  instruction memory returns data this cycle
imem_data  in  5  instruction opcode, valid when imem_ack=1
resume  in  1  pulse; leave HALT
step_mode  in  1  level; pause after every instruction
step  in  1  pulse; execute next instruction while paused
state  out  3  one-hot to decoder: [0]=fetch, [1]=exec1, [2]=exec2; 000 otherwise
ir  out  5  instruction register to decoder
imem_req  out  1  instruction fetch request
halted  out  1  core in HALT
fault  out  1  sticky fault flag
fault_code  out  2  01 overflow, 10 underflow, 11 fetch timeout, 00 none
stack_depth  out  DW  current call-stack occupancy
instr_count  out  16  retired-instruction counter

Behaviour:
- Reset (synchronous, active-high, any state, mid-instruction included):
  - FSM goes to IDLE.
  - state=000, ir=0, imem_req=0, halted=0, fault=0, fault_code=00, stack_depth=0, instr_count=0, timeout counter=0.
- FSM states: IDLE, FREQ, FETCH, EXEC1, EXEC2, PAUSE, HALT, FAULT.
- The `state` output is registered and decoded from the FSM: 001 only in FETCH, 010 only in EXEC1, 100 only in EXEC2, 000 in all other states.
- IDLE: run=1 -> FREQ. run is sampled only in IDLE; deasserting it later has no effect.
- FREQ:
  - imem_req=1 (registered state decode, not combinational from inputs).
  - On imem_ack=1: ir<=imem_data, go to FETCH, clear timeout counter.
  - Otherwise increment the timeout counter. If the counter reaches ACK_TIMEOUT without ack -> FAULT, code 11.
  - An ack in the same cycle the count would reach ACK_TIMEOUT wins (no fault).
- FETCH (state=001), stack check on ir:
  - ir==CALL_OP and stack_depth==STACK_DEPTH -> FAULT, code 01.
  - ir==RET_OP and stack_depth==0 -> FAULT, code 10.
  - Otherwise -> EXEC1.
  - EXEC1 is never entered for a faulting instruction, so the decoder never asserts push/pop for it.
- EXEC1 (state=010):
  - ir==HALT_OP: instr_count+1, go to HALT; EXEC2 is skipped.
  - Else stack_depth +1 for CALL_OP, -1 for RET_OP, unchanged otherwise; go to EXEC2.
- EXEC2 (state=100): instr_count+1, wrapping at 16 bits. Next state is PAUSE if step_mode=1, else FREQ.
- PAUSE:
  - step=1 -> FREQ.
  - Clearing step_mode while in PAUSE -> FREQ the next cycle.
  - resume is ignored.
- HALT:
  - halted=1.
  - resume=1 -> FREQ, halted clears with the state.
  - run and step are ignored.
- FAULT:
  - fault=1 and fault_code hold until reset. Only reset exits.
  - ir and stack_depth freeze.
- Latency: with imem_ack returned in the first FREQ cycle, a normal instruction takes 4 cycles (FREQ, FETCH, EXEC1, EXEC2) and a HALT instruction takes 3.
- Simultaneous inputs:
  - In PAUSE, step and resume together -> step is taken.
  - A reset together with any other input -> reset wins.
- ir holds its value from FETCH until the next imem_ack.

Test Plan:
- Basic flow: reset, run=1, ack every FREQ cycle with opcode 00011 ×3 -> state sequence 000,001,010,100 repeats; imem_req high 1 cycle/instr; instr_count=3 after 12 cycles of execution.
- Stack: 4×CALL_OP -> stack_depth 1..4; 5th CALL_OP -> FETCH then FAULT, fault_code=01, state never 010 for it; RET_OP at depth 0 after reset -> fault_code=10.
- Timeout: hold imem_ack=0 in FREQ -> fault=1, fault_code=11 after 15 cycles; ack on cycle 15 -> no fault, FETCH follows.
- Halt/resume: HALT_OP fetched -> states 001,010 then halted=1, instr_count+1, no 100; resume pulse -> imem_req next cycle, halted=0.
- Single-step: step_mode=1 -> PAUSE after each EXEC2, state=000 until step pulse; step+resume same cycle -> FREQ; clear step_mode in PAUSE -> free-run resumes.
- Reset mid-instruction: assert reset during EXEC1 of CALL_OP -> next cycle all outputs zero, stack_depth=0, FSM IDLE.
